fft_ctrl: RTL and testbench

FFT_CTRL -- requirements
Module: fft_ctrl

---
 rtl/fft_pkg.sv | 39 +++
 rtl/fft_buffer.sv | 46 ++++
 rtl/fft_ctrl.sv | 153 +++++++++++++++
 tb/tb_fft_ctrl.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// Shared types, sizes and address helpers for the 16-point radix-4 FFT controller.
package fft_pkg;

    localparam int unsigned N        = 16;
    localparam int unsigned SAMPLE_W = 34;
    localparam int unsigned COMP_W   = 17;
    localparam int unsigned ADDR_W   = 4;
    localparam int unsigned RADIX    = 4;
    localparam int unsigned NUM_OPS  = 8;
    localparam int unsigned OP_W     = 3;
    localparam int unsigned BF_W     = RADIX * SAMPLE_W;

    typedef enum logic [1:0] {
        ST_LOAD   = 2'd0,
        ST_CALC   = 2'd1,
        ST_UNLOAD = 2'd2
    } state_t;

    // One complex sample, real part in the upper half.
    typedef struct packed {
        logic [COMP_W-1:0] re;
        logic [COMP_W-1:0] im;
    } sample_t;

    typedef logic [RADIX-1:0][ADDR_W-1:0] addr_vec_t;
    typedef sample_t [RADIX-1:0]          data_vec_t;

    // Base-4 digit swap: load order n lands at {n[1:0], n[3:2]}.
    function automatic logic [ADDR_W-1:0] digit_rev(input logic [ADDR_W-1:0] n);
        return {n[1:0], n[3:2]};
    endfunction

    // Stage 0 works on contiguous groups (4i+j), stage 1 on strided groups (p+4j).
    function automatic logic [ADDR_W-1:0] calc_addr(input logic [OP_W-1:0] op,
                                                    input logic [1:0]      slot);
        return op[2] ? {slot, op[1:0]} : {op[1:0], slot};
    endfunction

endpackage

// File: rtl/fft_buffer.sv
// 16-entry sample store: one load write port, four in-place read/write ports
// for the butterfly, and one read port for unloading.
module fft_buffer
    import fft_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               load_we,
    input  logic [ADDR_W-1:0]  load_addr,
    input  sample_t            load_data,
    input  logic               calc_we,
    input  addr_vec_t          rw_addr,
    input  data_vec_t          wr_data,
    output data_vec_t          rd_data_c,
    input  logic [ADDR_W-1:0]  out_addr,
    output sample_t            out_data_c
);

    sample_t mem [N];

    // Load and calc writes never overlap: they belong to different states.
    always_ff @(posedge clk or posedge rst) begin : mem_write
        if (rst) begin
            for (int e = 0; e < int'(N); e++) begin
                mem[e] <= '0;
            end
        end else begin
            if (load_we) begin
                mem[load_addr] <= load_data;
            end
            if (calc_we) begin
                for (int j = 0; j < int'(RADIX); j++) begin
                    mem[rw_addr[j]] <= wr_data[j];
                end
            end
        end
    end

    always_comb begin : mem_read
        for (int j = 0; j < int'(RADIX); j++) begin
            rd_data_c[j] = mem[rw_addr[j]];
        end
        out_data_c = mem[out_addr];
    end

endmodule

// File: rtl/fft_ctrl.sv
// Sequencer for a 16-point radix-4 FFT: digit-reversed load, eight in-place
// butterfly ops through an external butterfly, then natural-order unload.
module fft_ctrl
    import fft_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [SAMPLE_W-1:0]  in_data,
    output logic [BF_W-1:0]      bf_in,
    output logic [OP_W-1:0]      bf_rot,
    input  logic [BF_W-1:0]      bf_out,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [SAMPLE_W-1:0]  out_data,
    output logic                 busy,
    output logic                 frame_done
);

    state_t              state;
    state_t              state_nxt;
    logic [ADDR_W-1:0]   in_cnt;
    logic [ADDR_W-1:0]   in_cnt_nxt;
    logic [OP_W-1:0]     op_cnt;
    logic [OP_W-1:0]     op_cnt_nxt;
    logic [ADDR_W-1:0]   out_cnt;
    logic [ADDR_W-1:0]   out_cnt_nxt;
    logic                in_ready_nxt;
    logic                out_valid_nxt;
    logic                busy_nxt;
    logic                frame_done_nxt;

    logic                in_fire_c;
    logic                out_fire_c;
    logic                load_we_c;
    logic                calc_we_c;
    addr_vec_t           rw_addr_c;
    data_vec_t           rd_data_c;
    sample_t             out_data_c;

    assign in_fire_c  = in_valid & in_ready & (state == ST_LOAD);
    assign out_fire_c = out_valid & out_ready & (state == ST_UNLOAD);

    always_ff @(posedge clk or posedge rst) begin : state_reg
        if (rst) begin
            state <= ST_LOAD;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state, counters and the registered handshake/status outputs.
    always_comb begin : next_state
        state_nxt      = state;
        in_cnt_nxt     = in_cnt;
        op_cnt_nxt     = op_cnt;
        out_cnt_nxt    = out_cnt;
        in_ready_nxt   = in_ready;
        out_valid_nxt  = out_valid;
        busy_nxt       = busy;
        frame_done_nxt = 1'b0;
        load_we_c      = 1'b0;
        calc_we_c      = 1'b0;

        unique case (state)
            ST_LOAD: begin
                if (in_fire_c) begin
                    load_we_c  = 1'b1;
                    in_cnt_nxt = in_cnt + ADDR_W'(1);
                    if (in_cnt == ADDR_W'(N - 1)) begin
                        state_nxt    = ST_CALC;
                        in_cnt_nxt   = '0;
                        in_ready_nxt = 1'b0;
                        busy_nxt     = 1'b1;
                    end
                end
            end
            ST_CALC: begin
                calc_we_c  = 1'b1;
                op_cnt_nxt = op_cnt + OP_W'(1);
                if (op_cnt == OP_W'(NUM_OPS - 1)) begin
                    state_nxt     = ST_UNLOAD;
                    op_cnt_nxt    = '0;
                    out_valid_nxt = 1'b1;
                end
            end
            ST_UNLOAD: begin
                if (out_fire_c) begin
                    out_cnt_nxt = out_cnt + ADDR_W'(1);
                    if (out_cnt == ADDR_W'(N - 1)) begin
                        state_nxt      = ST_LOAD;
                        out_cnt_nxt    = '0;
                        out_valid_nxt  = 1'b0;
                        busy_nxt       = 1'b0;
                        in_ready_nxt   = 1'b1;
                        frame_done_nxt = 1'b1;
                    end
                end
            end
            default: begin
                state_nxt = ST_LOAD;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin : ctrl_reg
        if (rst) begin
            in_cnt     <= '0;
            op_cnt     <= '0;
            out_cnt    <= '0;
            in_ready   <= 1'b1;
            out_valid  <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            in_cnt     <= in_cnt_nxt;
            op_cnt     <= op_cnt_nxt;
            out_cnt    <= out_cnt_nxt;
            in_ready   <= in_ready_nxt;
            out_valid  <= out_valid_nxt;
            busy       <= busy_nxt;
            frame_done <= frame_done_nxt;
        end
    end

    // op_cnt rests at zero outside CALC, so it doubles as the twiddle select.
    assign bf_rot = op_cnt;

    always_comb begin : rw_addr_gen
        for (int j = 0; j < int'(RADIX); j++) begin
            rw_addr_c[j] = calc_addr(op_cnt, 2'(j));
        end
    end

    fft_buffer u_buffer (
        .clk        (clk),
        .rst        (rst),
        .load_we    (load_we_c),
        .load_addr  (digit_rev(in_cnt)),
        .load_data  (sample_t'(in_data)),
        .calc_we    (calc_we_c),
        .rw_addr    (rw_addr_c),
        .wr_data    (data_vec_t'(bf_out)),
        .rd_data_c  (rd_data_c),
        .out_addr   (out_cnt),
        .out_data_c (out_data_c)
    );

    assign bf_in    = BF_W'(rd_data_c);
    assign out_data = SAMPLE_W'(out_data_c);

endmodule

// File: tb/tb_fft_ctrl.sv
// Directed/randomized bench for fft_ctrl with a behavioural butterfly and a
// staged radix-4 golden DFT model.
module tb_fft_ctrl;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [33:0]  in_data;
    logic [135:0] bf_in;
    logic [2:0]   bf_rot;
    logic [135:0] bf_out;
    logic         out_valid;
    logic         out_ready;
    logic [33:0]  out_data;
    logic         busy;
    logic         frame_done;

    int pass_cnt  = 0;
    int total_cnt = 0;
    int fail_cnt  = 0;
    int fd_cnt    = 0;

    logic [33:0] cur  [16];
    logic [33:0] gold [16];
    logic [33:0] got  [16];

    fft_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .bf_in      (bf_in),
        .bf_rot     (bf_rot),
        .bf_out     (bf_out),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .busy       (busy),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!rst && frame_done) fd_cnt++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog expired");
    end

    // ---------------- reference arithmetic ----------------
    function automatic longint sre(input logic [33:0] s);
        logic signed [16:0] t;
        t = s[33:17];
        return longint'(t);
    endfunction

    function automatic longint sim(input logic [33:0] s);
        logic signed [16:0] t;
        t = s[16:0];
        return longint'(t);
    endfunction

    function automatic logic [33:0] mk(input longint re, input longint im);
        logic [16:0] r;
        logic [16:0] i;
        r = 17'(re);
        i = 17'(im);
        return {r, i};
    endfunction

    // Multiply by W16^e = cos - j*sin, Q14 constants, floor rounding.
    function automatic logic [33:0] twmul(input logic [33:0] s, input int e);
        longint c, sn, ar, ai;
        case (e)
            0: begin c = 16384;  sn = 0;     end
            1: begin c = 15137;  sn = 6270;  end
            2: begin c = 11585;  sn = 11585; end
            3: begin c = 6270;   sn = 15137; end
            4: begin c = 0;      sn = 16384; end
            5: begin c = -6270;  sn = 15137; end
            6: begin c = -11585; sn = 11585; end
            7: begin c = -15137; sn = 6270;  end
            8: begin c = -16384; sn = 0;     end
            9: begin c = -15137; sn = -6270; end
            default: begin c = 16384; sn = 0; end
        endcase
        ar = sre(s);
        ai = sim(s);
        return mk((ar * c + ai * sn) >>> 14, (ai * c - ar * sn) >>> 14);
    endfunction

    // Output m of a 4-point DFT of (a,b,c,d).
    function automatic logic [33:0] dft4(input logic [33:0] a, input logic [33:0] b,
                                         input logic [33:0] c, input logic [33:0] d,
                                         input int m);
        longint ar, ai, br, bi, cr, ci, dr, di;
        ar = sre(a); ai = sim(a); br = sre(b); bi = sim(b);
        cr = sre(c); ci = sim(c); dr = sre(d); di = sim(d);
        case (m)
            0: return mk(ar + br + cr + dr, ai + bi + ci + di);
            1: return mk(ar + bi - cr - di, ai - br - ci + dr);
            2: return mk(ar - br + cr - dr, ai - bi + ci - di);
            default: return mk(ar - bi - cr + di, ai + br - ci - dr);
        endcase
    endfunction

    // Butterfly: ops 0..3 plain DFT4; ops 4..7 (p = rot-4) twiddle slot j by W16^(j*p) first.
    function automatic logic [135:0] bfly(input logic [2:0] rot, input logic [135:0] x);
        logic [33:0]  a [4];
        logic [135:0] y;
        for (int j = 0; j < 4; j++) begin
            a[j] = x[34*j +: 34];
            if (rot >= 3'd4) a[j] = twmul(a[j], j * (int'(rot) - 4));
        end
        y = '0;
        for (int m = 0; m < 4; m++) y[34*m +: 34] = dft4(a[0], a[1], a[2], a[3], m);
        return y;
    endfunction

    assign bf_out = bfly(bf_rot, bf_in);

    // X[p+4q] = sum_j W16^(jp) W4^(jq) Y_j[p], Y_j = DFT4 of x[j], x[j+4], x[j+8], x[j+12].
    task automatic compute_golden();
        logic [33:0] y [4][4];
        for (int i = 0; i < 4; i++)
            for (int m = 0; m < 4; m++)
                y[i][m] = dft4(cur[i], cur[i+4], cur[i+8], cur[i+12], m);
        for (int p = 0; p < 4; p++)
            for (int q = 0; q < 4; q++)
                gold[p + 4*q] = dft4(twmul(y[0][p], 0), twmul(y[1][p], p),
                                     twmul(y[2][p], 2*p), twmul(y[3][p], 3*p), q);
    endtask

    function automatic logic [33:0] rnd_sample();
        return mk(longint'(int'($urandom_range(0, 4000)) - 2000),
                  longint'(int'($urandom_range(0, 4000)) - 2000));
    endfunction

    task automatic random_frame();
        for (int n = 0; n < 16; n++) cur[n] = rnd_sample();
        compute_golden();
    endtask

    // ---------------- checking and stimulus helpers ----------------
    task automatic check(input string tag, input logic [135:0] obs, input logic [135:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input bit gaps);
        int n = 0;
        int guard = 0;
        while (n < 16 && guard < 500) begin
            if (gaps && $urandom_range(0, 3) == 0) begin
                in_valid = 1'b0;
                in_data  = 34'($urandom);
            end else begin
                in_valid = 1'b1;
                in_data  = cur[n];
                if (in_ready) n++;
            end
            tick();
            guard++;
        end
        in_valid = 1'b0;
        check("send_count", 136'(n), 136'(16));
    endtask

    task automatic recv_frame(input bit rnd);
        int          k = 0;
        int          guard = 0;
        bit          stalled = 1'b0;
        logic [33:0] held = '0;
        while (k < 16 && guard < 2000) begin
            out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (out_valid) begin
                if (stalled) check("stall_hold", 136'(out_data), 136'(held));
                if (out_ready) begin
                    check($sformatf("out_k%0d", k), 136'(out_data), 136'(gold[k]));
                    got[k]  = out_data;
                    k++;
                    stalled = 1'b0;
                end else begin
                    stalled = 1'b1;
                    held    = out_data;
                end
            end
            tick();
            guard++;
        end
        out_ready = 1'b0;
        check("recv_count", 136'(k), 136'(16));
        check("done_pulse", 136'(frame_done), 136'(1));
        check("done_busy",  136'(busy), 136'(0));
        check("done_ready", 136'(in_ready), 136'(1));
        check("done_valid", 136'(out_valid), 136'(0));
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int           fd0;
        int           n;
        int           c;
        int           guard;
        logic [33:0]  imp;
        logic [135:0] expv;

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        imp       = {17'd256, 17'd0};
        repeat (3) tick();
        check("rst_in_ready",   136'(in_ready), 136'(1));
        check("rst_out_valid",  136'(out_valid), 136'(0));
        check("rst_busy",       136'(busy), 136'(0));
        check("rst_frame_done", 136'(frame_done), 136'(0));
        check("rst_bf_rot",     136'(bf_rot), 136'(0));
        rst = 1'b0;
        tick();

        // Impulse frame.
        for (int i = 0; i < 16; i++) cur[i] = (i == 0) ? imp : 34'd0;
        compute_golden();
        fd0 = fd_cnt;
        send_frame(1'b0);
        recv_frame(1'b0);
        tick();
        for (int k = 0; k < 16; k++) check($sformatf("impulse_k%0d", k), 136'(got[k]), 136'(imp));
        check("impulse_fd", 136'(fd_cnt - fd0), 136'(1));

        // in_valid held high: ready-low window and op sequence; garbage offered meanwhile.
        random_frame();
        out_ready = 1'b1;
        n = 0;
        guard = 0;
        while (n < 16 && guard < 100) begin
            in_valid = 1'b1;
            in_data  = cur[n];
            if (in_ready) n++;
            tick();
            guard++;
        end
        check("hold_send_count", 136'(n), 136'(16));
        c = 0;
        while (!in_ready && c < 100) begin
            in_data = 34'($urandom);
            if (c < 8) check($sformatf("hold_rot%0d", c), 136'(bf_rot), 136'(c));
            else if (c < 24) check($sformatf("hold_out%0d", c - 8), 136'(out_data), 136'(gold[c - 8]));
            tick();
            c++;
        end
        in_valid = 1'b0;
        check("hold_ready_low_cycles", 136'(c), 136'(24));
        check("hold_done_pulse", 136'(frame_done), 136'(1));
        check("hold_done_busy", 136'(busy), 136'(0));
        out_ready = 1'b0;
        tick();

        // Address check: sample n carries n in the real part.
        for (int i = 0; i < 16; i++) cur[i] = {17'(i), 17'd0};
        compute_golden();
        send_frame(1'b1);
        check("addr_op0_rot", 136'(bf_rot), 136'(0));
        check("addr_op0_in", bf_in, {cur[12], cur[8], cur[4], cur[0]});
        repeat (4) tick();
        check("addr_op4_rot", 136'(bf_rot), 136'(4));
        expv = '0;
        for (int j = 0; j < 4; j++) expv[34*j +: 34] = mk(longint'(4*j + 24), 0);
        check("addr_op4_in", bf_in, expv);
        recv_frame(1'b1);

        // Reset during CALC at op 3, then a clean frame.
        random_frame();
        send_frame(1'b1);
        repeat (3) tick();
        check("rst_op3_rot", 136'(bf_rot), 136'(3));
        #1 rst = 1'b1;
        #1;
        check("mid_rst_in_ready",  136'(in_ready), 136'(1));
        check("mid_rst_out_valid", 136'(out_valid), 136'(0));
        check("mid_rst_busy",      136'(busy), 136'(0));
        check("mid_rst_bf_rot",    136'(bf_rot), 136'(0));
        tick();
        rst = 1'b0;
        tick();
        random_frame();
        fd0 = fd_cnt;
        send_frame(1'b1);
        recv_frame(1'b1);
        tick();
        check("post_rst_fd", 136'(fd_cnt - fd0), 136'(1));

        // Two back-to-back frames with independent data.
        fd0 = fd_cnt;
        random_frame();
        send_frame(1'b0);
        recv_frame(1'b1);
        random_frame();
        send_frame(1'b0);
        recv_frame(1'b1);
        tick();
        check("b2b_fd", 136'(fd_cnt - fd0), 136'(2));

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
